// File: rtl/ref_mem_pkg.sv
// Shared sizes, FSM states and read-mode encodings for the reference-window memory sequencer.
package ref_mem_pkg;

  localparam int NBANK     = 32;
  localparam int DEPTH     = 96;
  localparam int GRP       = 4;
  localparam int AW        = 7;
  localparam int NGRP      = NBANK / GRP;
  localparam int WIN_BEATS = DEPTH * NGRP;
  localparam int PW        = 10;

  localparam logic RD_MODE_8ROW = 1'b0;
  localparam logic RD_MODE_1ROW = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    RD8   = 2'd2,
    RD1   = 2'd3
  } state_t;

  // Folds an entry index in 0..127 back into 0..95; one subtraction covers that range.
  function automatic logic [AW-1:0] entry_mod(input logic [AW-1:0] e);
    return (e >= AW'(DEPTH)) ? e - AW'(DEPTH) : e;
  endfunction

endpackage

// File: rtl/ref_wr_addr_gen.sv
// Write pointer walk: each beat drives one 4-bank group at entry wr_ptr>>3, registered one cycle.
// No backpressure of its own; wr_clr has priority over a beat and drops it.
module ref_wr_addr_gen
  import ref_mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_fire,
  input  logic                wr_clr,
  output logic [NBANK-1:0]    bank_sel,
  output logic [NBANK*AW-1:0] wr_addr_all,
  output logic                win_full
);

  logic [PW-1:0] wr_ptr;
  logic [2:0]    grp;
  logic [AW-1:0] entry;

  assign grp   = wr_ptr[2:0];
  assign entry = wr_ptr[PW-1:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      win_full    <= 1'b0;
      bank_sel    <= '0;
      wr_addr_all <= '0;
    end else begin
      bank_sel <= '0;
      if (wr_clr) begin
        wr_ptr   <= '0;
        win_full <= 1'b0;
      end else if (wr_fire) begin
        for (int j = 0; j < NBANK; j++) begin
          if (3'(j / GRP) == grp) begin
            bank_sel[j]              <= 1'b1;
            wr_addr_all[AW*j +: AW] <= entry;
          end
        end
        if (wr_ptr == PW'(WIN_BEATS - 1)) begin
          wr_ptr   <= '0;
          win_full <= 1'b1;
        end else begin
          wr_ptr <= wr_ptr + PW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/ref_mem_ctrl.sv
// Reference-window memory sequencer: write stream to bank enables, read commands to RD8/RD1 sequences.
// Outputs registered (first read 1 cycle after rd_ack); wr_ready drops while a read owns the memory.
// Optional counters under REF_MEM_CTRL_PERF_EN.
module ref_mem_ctrl
  import ref_mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic                wr_clr,
  input  logic                rd_req,
  input  logic                rd_mode,
  input  logic [AW-1:0]       rd_start,
  input  logic [AW-1:0]       rd_len,
  output logic                rd_ack,
  output logic [NBANK-1:0]    bank_sel,
  output logic [NBANK*AW-1:0] wr_addr_all,
  output logic [AW-1:0]       rd_address,
  output logic                rd8r_en,
  output logic [3:0]          rdr_sel,
  output logic                rd_done,
  output logic                busy,
  output logic                win_full
`ifdef REF_MEM_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_rd_cyc,
  output logic [31:0]         perf_wr_stall
`endif
);

  state_t        state, state_nxt;
  logic          wr_accept;
  logic [AW-1:0] cur_q, cur_nxt;
  logic [AW-1:0] rem_q, rem_nxt;
  logic [2:0]    sub_q, sub_nxt;
  logic          ack_nxt, done_nxt, en_nxt;
  logic [3:0]    sel_nxt;
  logic [AW-1:0] addr_nxt;

  assign wr_ready  = rst_n & (((state == IDLE) & ~rd_req) | (state == WRITE));
  assign wr_accept = wr_valid & wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ack_nxt   = 1'b0;
    done_nxt  = 1'b0;
    en_nxt    = 1'b1;
    sel_nxt   = 4'd0;
    addr_nxt  = rd_address;
    cur_nxt   = cur_q;
    rem_nxt   = rem_q;
    sub_nxt   = sub_q;
    case (state)
      IDLE: begin
        if (rd_req) begin
          ack_nxt   = 1'b1;
          state_nxt = (rd_mode == RD_MODE_1ROW) ? RD1 : RD8;
          cur_nxt   = entry_mod(rd_start);
          rem_nxt   = (rd_len == '0) ? AW'(1) : rd_len;
          sub_nxt   = 3'd0;
        end else if (wr_accept) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (!wr_valid) state_nxt = IDLE;
      end
      RD8: begin
        if (rem_q != '0) begin
          en_nxt   = 1'b0;
          addr_nxt = cur_q;
          cur_nxt  = entry_mod(cur_q + AW'(1));
          rem_nxt  = rem_q - AW'(1);
        end else begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      RD1: begin
        // Eight row-select cycles per entry; only the first re-arms the read enable.
        if (rem_q != '0) begin
          en_nxt   = (sub_q != 3'd0);
          sel_nxt  = {1'b0, sub_q} + 4'd1;
          addr_nxt = cur_q;
          sub_nxt  = sub_q + 3'd1;
          if (sub_q == 3'd7) begin
            cur_nxt = entry_mod(cur_q + AW'(1));
            rem_nxt = rem_q - AW'(1);
          end
        end else begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ack     <= 1'b0;
      rd_done    <= 1'b0;
      rd8r_en    <= 1'b1;
      rdr_sel    <= 4'd0;
      rd_address <= '0;
      busy       <= 1'b0;
      cur_q      <= '0;
      rem_q      <= '0;
      sub_q      <= 3'd0;
    end else begin
      rd_ack     <= ack_nxt;
      rd_done    <= done_nxt;
      rd8r_en    <= en_nxt;
      rdr_sel    <= sel_nxt;
      rd_address <= addr_nxt;
      busy       <= (state_nxt != IDLE);
      cur_q      <= cur_nxt;
      rem_q      <= rem_nxt;
      sub_q      <= sub_nxt;
    end
  end

  ref_wr_addr_gen u_wr_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_fire     (wr_accept),
    .wr_clr      (wr_clr),
    .bank_sel    (bank_sel),
    .wr_addr_all (wr_addr_all),
    .win_full    (win_full)
  );

`ifdef REF_MEM_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_rd_cyc   <= '0;
      perf_wr_stall <= '0;
    end else if (wr_clr) begin
      perf_rd_cyc   <= '0;
      perf_wr_stall <= '0;
    end else begin
      if (((state == RD8) || (state == RD1)) && (perf_rd_cyc != '1))
        perf_rd_cyc <= perf_rd_cyc + 32'd1;
      if (wr_valid && !wr_ready && (perf_wr_stall != '1))
        perf_wr_stall <= perf_wr_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ref_mem_ctrl.sv
// Directed bench for ref_mem_ctrl: write walk, window wrap, RD8/RD1 bursts, arbitration and reset abort.
module tb_ref_mem_ctrl;
  import ref_mem_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                wr_valid = 1'b0;
  logic                wr_ready;
  logic                wr_clr = 1'b0;
  logic                rd_req = 1'b0;
  logic                rd_mode = 1'b0;
  logic [AW-1:0]       rd_start = '0;
  logic [AW-1:0]       rd_len = '0;
  logic                rd_ack;
  logic [NBANK-1:0]    bank_sel;
  logic [NBANK*AW-1:0] wr_addr_all;
  logic [AW-1:0]       rd_address;
  logic                rd8r_en;
  logic [3:0]          rdr_sel;
  logic                rd_done;
  logic                busy;
  logic                win_full;
`ifdef REF_MEM_CTRL_PERF_EN
  logic [31:0]         perf_rd_cyc;
  logic [31:0]         perf_wr_stall;
`endif

  int checks = 0;
  int errors = 0;
  int exp_rd8 [4] = '{94, 95, 0, 1};

  always #5 clk = ~clk;

  ref_mem_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_clr      (wr_clr),
    .rd_req      (rd_req),
    .rd_mode     (rd_mode),
    .rd_start    (rd_start),
    .rd_len      (rd_len),
    .rd_ack      (rd_ack),
    .bank_sel    (bank_sel),
    .wr_addr_all (wr_addr_all),
    .rd_address  (rd_address),
    .rd8r_en     (rd8r_en),
    .rdr_sel     (rdr_sel),
    .rd_done     (rd_done),
    .busy        (busy),
    .win_full    (win_full)
`ifdef REF_MEM_CTRL_PERF_EN
    ,
    .perf_rd_cyc   (perf_rd_cyc),
    .perf_wr_stall (perf_wr_stall)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset values
    #2 rst_n = 1'b0;
    tick();
    tick();
    check("rst_rd8r_en", rd8r_en, 1);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_bank_sel", bank_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_win_full", win_full, 0);
    check("rst_rd_ack", rd_ack, 0);
    check("rst_rd_done", rd_done, 0);
    check("rst_rdr_sel", rdr_sel, 0);
    check("rst_addr_all", wr_addr_all, 0);
    rst_n = 1'b1;
    tick();

    // Nine beats: groups 0..7 at entry 0, then group 0 at entry 1
    wr_valid = 1'b1;
    #1 check("idle_wr_ready", wr_ready, 1);
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("walk_bank_sel_%0d", i), bank_sel, 32'hF << (4 * (i % 8)));
      check($sformatf("walk_addr_%0d", i), wr_addr_all[AW*(4*(i%8)) +: AW], (i < 8) ? 0 : 1);
      check($sformatf("walk_busy_%0d", i), busy, 1);
    end
    wr_valid = 1'b0;
    tick();
    check("walk_end_bank_sel", bank_sel, 0);
    check("walk_end_busy", busy, 0);
    check("walk_addr_all", wr_addr_all, 224'h204081);

    // Full window after wr_clr
    wr_clr = 1'b1;
    tick();
    wr_clr = 1'b0;
    wr_valid = 1'b1;
    for (int i = 1; i <= 769; i++) begin
      tick();
      if (i == 767) check("win_full_before", win_full, 0);
      if (i == 768) begin
        check("win_full_after", win_full, 1);
        check("last_beat_bank_sel", bank_sel, 32'hF000_0000);
        check("last_beat_addr", wr_addr_all[AW*31 +: AW], 95);
      end
    end
    check("wrap_bank_sel", bank_sel, 32'h0000_000F);
    check("wrap_addr", wr_addr_all[0 +: AW], 0);
    wr_valid = 1'b0;
    tick();

    // RD8 across the 95 -> 0 boundary
    rd_req = 1'b1; rd_mode = 1'b0; rd_start = 7'd94; rd_len = 7'd4;
    #1 check("rd8_wr_ready_low", wr_ready, 0);
    tick();
    rd_req = 1'b0;
    check("rd8_ack", rd_ack, 1);
    check("rd8_busy", busy, 1);
    check("rd8_en_idle", rd8r_en, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("rd8_en_%0d", k), rd8r_en, 0);
      check($sformatf("rd8_addr_%0d", k), rd_address, exp_rd8[k]);
      check($sformatf("rd8_sel_%0d", k), rdr_sel, 0);
      check($sformatf("rd8_done_early_%0d", k), rd_done, 0);
    end
    tick();
    check("rd8_done", rd_done, 1);
    check("rd8_en_off", rd8r_en, 1);
    check("rd8_busy_off", busy, 0);
    tick();
    check("rd8_done_pulse", rd_done, 0);

    // RD1: two entries, eight row selects each; a stray rd_req mid-burst is ignored
    rd_req = 1'b1; rd_mode = 1'b1; rd_start = 7'd5; rd_len = 7'd2;
    tick();
    rd_req = 1'b0;
    check("rd1_ack", rd_ack, 1);
    for (int c = 0; c < 16; c++) begin
      rd_req = (c == 2);
      tick();
      check($sformatf("rd1_sel_%0d", c), rdr_sel, (c % 8) + 1);
      check($sformatf("rd1_addr_%0d", c), rd_address, (c < 8) ? 5 : 6);
      check($sformatf("rd1_en_%0d", c), rd8r_en, ((c % 8) == 0) ? 0 : 1);
      check($sformatf("rd1_no_ack_%0d", c), rd_ack, 0);
    end
    rd_req = 1'b0;
    tick();
    check("rd1_done", rd_done, 1);
    check("rd1_sel_off", rdr_sel, 0);
    check("rd1_en_off", rd8r_en, 1);
    tick();

    // rd_start above 95 folds, rd_len 0 reads one entry
    rd_req = 1'b1; rd_mode = 1'b0; rd_start = 7'd100; rd_len = 7'd0;
    tick();
    rd_req = 1'b0;
    tick();
    check("fold_addr", rd_address, 4);
    check("fold_en", rd8r_en, 0);
    tick();
    check("len0_done", rd_done, 1);
    tick();

    // Read wins over a simultaneous write; beat waits until IDLE
    rd_req = 1'b1; wr_valid = 1'b1; rd_mode = 1'b0; rd_start = 7'd10; rd_len = 7'd1;
    #1 check("arb_wr_ready", wr_ready, 0);
    tick();
    rd_req = 1'b0;
    check("arb_ack", rd_ack, 1);
    check("arb_no_beat", bank_sel, 0);
    check("arb_busy_ready", wr_ready, 0);
    tick();
    check("arb_addr", rd_address, 10);
    check("arb_no_beat2", bank_sel, 0);
    tick();
    check("arb_done", rd_done, 1);
    check("arb_ready_idle", wr_ready, 1);
    tick();
    check("arb_beat", bank_sel, 32'h0000_00F0);
    tick();
    check("beat2", bank_sel, 32'h0000_0F00);
    check("full_before_clr", win_full, 1);

    // wr_clr drops the concurrent beat and rewinds the pointer
    wr_clr = 1'b1;
    tick();
    wr_clr = 1'b0;
    check("clr_drop", bank_sel, 0);
    check("clr_full", win_full, 0);
    tick();
    check("clr_restart", bank_sel, 32'h0000_000F);
    check("clr_restart_addr", wr_addr_all[0 +: AW], 0);
    wr_valid = 1'b0;
    tick();
    check("clr_idle", busy, 0);

    // Reset in the middle of a long RD8 burst
    rd_req = 1'b1; rd_mode = 1'b0; rd_start = 7'd0; rd_len = 7'd50;
    tick();
    rd_req = 1'b0;
    tick();
    tick();
    check("abort_active", rd8r_en, 0);
    rst_n = 1'b0;
    #1;
    check("abort_en", rd8r_en, 1);
    check("abort_bank_sel", bank_sel, 0);
    check("abort_busy", busy, 0);
    check("abort_done", rd_done, 0);
    tick();
    tick();
    check("abort_no_done", rd_done, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check("abort_post_done", rd_done, 0);
    check("abort_post_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ref_mem_ctrl.md
Name: ref_mem_ctrl

Overview:
- Sequencer for the 32-bank reference-window memory (32 banks × 96 entries × 64 bit).
- Turns a streaming write channel into per-bank write enables and write addresses.
- Turns read commands into address and read-enable sequences, in either 8-row mode (one entry per cycle) or 1-row mode (8 row-select cycles per entry).
- Arbitrates writes and reads onto the shared memory, one operation class at a time.

Parameters:
NBANK, 32, number of banks
DEPTH, 96, entries per bank
GRP, 4, banks written per beat (256-bit write word = GRP × 64 bit)
AW, 7, entry address width

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
wr_valid  in  1  write beat valid (data goes to the memory directly)
wr_ready  out  1  write beat accepted when wr_valid & wr_ready
wr_clr  in  1  one-cycle pulse: reset write pointer and clear win_full
rd_req  in  1  read command valid (sampled only in IDLE)
rd_mode  in  1  0 = 8-row, 1 = 1-row
rd_start  in  AW  first entry (0..95)
rd_len  in  AW  entries to read (1..96; 0 treated as 1)
rd_ack  out  1  one-cycle pulse: command accepted
bank_sel  out  NBANK  active-high write enable per bank (memory side inverts)
wr_addr_all  out  NBANK*AW  per-bank write address, bank j at [AW*j +: AW]
rd_address  out  AW  read entry address
rd8r_en  out  1  active-low read enable
rdr_sel  out  4  0 = all 8 rows, 1..8 = single row
rd_done  out  1  one-cycle pulse after last read cycle
busy  out  1  state != IDLE
win_full  out  1  all 768 beats written since reset or wr_clr

Behaviour:
- Reset (rst_n async, active-low): state IDLE; wr_ptr = 0; every output 0, except rd8r_en = 1 and wr_ready = 0 during reset.
- FSM states: IDLE, WRITE, RD8, RD1. All outputs are registered except wr_ready.
- wr_ready = (state == IDLE & !rd_req) | state == WRITE.

Write path:
- wr_ptr is 10 bits, range 0..767.
- Group g = wr_ptr[2:0]; entry e = wr_ptr >> 3.
- Accepted beat: next cycle bank_sel has bits [4g +: 4] = 1 and all others 0. The wr_addr_all slices of those 4 banks = e; other slices hold their value.
- wr_ptr increments per accepted beat and wraps 767 → 0; win_full sets on the wrap.
- IDLE → WRITE on an accepted beat. WRITE → IDLE on the first cycle with no beat; bank_sel = 0 that cycle.

Read path:
- Read priority: in IDLE, rd_req wins. wr_ready = 0 in that cycle and rd_ack pulses.
- rd_start, rd_mode and rd_len are latched on acceptance.
- RD8: for rd_len cycles, rd8r_en = 0, rdr_sel = 0, rd_address = start + k mod 96 (95 → 0 wrap).
- RD1: per entry, rd8r_en = 0 on the first cycle only. rdr_sel steps 1..8 over 8 cycles with rd_address held. Total length rd_len × 8 cycles.
- First read output appears 1 cycle after the rd_ack cycle.
- After the last read cycle: rd8r_en = 1, rdr_sel = 0, rd_done pulses, state → IDLE.
- rd_req outside IDLE is ignored; there is no rd_ack and no queuing.
- wr_clr takes effect in any state. During WRITE it overrides an accepted beat: that beat is dropped and wr_ptr = 0.
- Reset mid-burst aborts immediately. No rd_done is produced.
- rd_start > 95 is taken mod 96.

Optional Feature:
- Macro REF_MEM_CTRL_PERF_EN.
- With the macro: adds outputs perf_rd_cyc[31:0] (cycles in RD8/RD1) and perf_wr_stall[31:0] (cycles with wr_valid & !wr_ready). Both saturate at all-ones and clear on reset or wr_clr.
- Without the macro: neither port nor logic exists, and behaviour is otherwise identical.

Decomposition:
- Package ref_mem_pkg: NBANK, DEPTH, GRP, AW, the state enum (IDLE/WRITE/RD8/RD1), the RD_MODE_8ROW/RD_MODE_1ROW constants and the beats-per-window constant (768).
- One sub-module, ref_wr_addr_gen: owns wr_ptr, generates bank_sel and wr_addr_all, and sets win_full.

Test Plan:
- Reset, then 8 beats → bank_sel = 0x0000000F, 0x000000F0, … 0xF0000000 on successive cycles, all slices addr 0. The 9th beat writes banks 0-3 at addr 1.
- 768 continuous beats → win_full rises after beat 768; the next beat targets banks 0-3 at addr 0.
- rd_mode = 0, start = 94, len = 4 → rd_address 94, 95, 0, 1 with rd8r_en low for 4 cycles, then rd_done 1 cycle later.
- rd_mode = 1, start = 5, len = 2 → 16 cycles: rdr_sel 1..8 at addr 5, then 1..8 at addr 6. rd8r_en low only on cycles 1 and 9.
- rd_req and wr_valid together in IDLE → rd_ack = 1 and wr_ready = 0. The beat is accepted on the first IDLE cycle after rd_done.
- rst_n low mid RD8 burst → rd8r_en = 1, bank_sel = 0 and busy = 0 immediately, with no rd_done.
